remote_link_rx: RTL and testbench
=================================

# remote_link_rx

Serial receiver for the board-to-board remote button link: the receiving end of the single-wire link whose transmitter drives the peer board's SPACE_TX/ENTER_TX pins. One instance per RX pin (SPACE_RX, ENTER_RX) sits inside top_vga in the clk65MHz domain. Each instance recovers UART-style frames from the peer and emits one-cycle strobes that the game logic treats exactly like local PS2 SPACE/ENTER presses.

## Interface
- CLK_HZ, 65_000_000, system clock frequency
- BAUD, 115_200, link bit rate
- CLKS_PER_BIT, CLK_HZ/BAUD (integer division = 564), clock cycles per bit
- CMD_CODE, 8'h20, byte that means "button pressed"; SPACE instance uses 8'h20, ENTER instance uses 8'h0D
- clk65MHz  in  1  system clock; all logic on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- rx  in  1  asynchronous serial line from peer; idle high
- rx_data  out  8  last received byte; holds until next good frame
- rx_valid  out  1  one-cycle strobe: good frame, rx_data updated same cycle
- btn_pulse  out  1  one-cycle strobe, coincident with rx_valid when rx_data == CMD_CODE
- frame_err  out  1  one-cycle strobe: bad stop bit (or parity, see Configuration)
- busy  out  1  high whenever FSM not in IDLE

## Operation
- rx passes a 2-FF synchronizer (async-reg attribute); all logic uses synchronized rx_s. Frame: start (0), 8 data bits LSB first, [parity], stop (1).
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, RECOVER.
- IDLE: rx_s == 0 -> START, bit counter cleared, cycle counter cleared.
- START: at count CLKS_PER_BIT/2 - 1 (281) sample rx_s; 0 -> DATA, counter cleared; 1 -> IDLE (glitch, no output).
- DATA: every CLKS_PER_BIT cycles (count 563) shift rx_s into MSB of shift register; after 8th sample -> PARITY or STOP.
- STOP: at count 563 sample; 1 -> rx_data <= shift reg, rx_valid pulse, btn_pulse if match, -> IDLE; 0 -> frame_err pulse, rx_data unchanged, -> RECOVER.
- RECOVER: stay until rx_s == 1 for one cycle, then IDLE (break/stuck-low line yields exactly one frame_err, not repeats).
- Counters: cycle counter width $clog2(CLKS_PER_BIT), bit counter 3 bits; counters never wrap mid-bit, cleared on every bit sample.
- rst in any state: FSM -> IDLE, counters 0, shift reg 0, synchronizer flops 1; in-flight frame discarded silently.

## Timing
- Reset values: rx_data 8'h00, rx_valid 0, btn_pulse 0, frame_err 0, busy 0.
- rx falling edge to IDLE->START transition: 3 cycles (2 sync + 1 detect).
- Sample points after start detection: start at +282, data bit n at +282+564*(n+1), stop at +282+564*9 (+564 more with parity).
- rx_valid/btn_pulse/frame_err registered, asserted the cycle after the stop sample, exactly 1 cycle wide, mutually exclusive for valid vs err.
- Back-to-back frames: next start bit accepted the cycle FSM returns to IDLE; receiver ready ~half a bit before nominal stop end, tolerates +/-2% baud mismatch.
- busy falls the same cycle rx_valid or (after RECOVER) line-high is seen.

## Configuration
- REMOTE_LINK_PARITY_EN defined: PARITY state inserted after DATA; even parity over 8 data bits sampled at count 563; mismatch -> frame_err pulse after stop sample, no rx_valid, then IDLE/RECOVER per stop value. Frame 11 bits.
- Not defined: no PARITY state, 10-bit frame; peer transmitter must use the same setting.

## Structure
- Shared package remote_link_pkg: state enum typedef, default BAUD, SPACE_CODE 8'h20, ENTER_CODE 8'h0D, parity macro guard helper; also used by the matching transmitter.
- Sub-module remote_link_sync: 2-FF synchronizer with reset-to-1, reusable for PS2 lines.

## Test plan
- Reset mid-frame: send 8'h20, assert rst at data bit 4 -> all outputs 0, no rx_valid, next clean 8'h20 received normally.
- Good frame 8'h20 on SPACE instance -> rx_data 8'h20, rx_valid and btn_pulse 1 cycle each, 282+564*9+1 cycles after start detect.
- Frame 8'h0D on SPACE instance -> rx_valid 1, rx_data 8'h0D, btn_pulse stays 0.
- Stop bit forced 0, line held low 5000 cycles -> single frame_err pulse, rx_data unchanged, busy high until line returns high.
- 200-cycle low glitch on idle line -> no outputs, busy back to 0 at start check.
- Back-to-back 8'hA5, 8'h5A with baud +2% -> two rx_valid pulses, correct data; with REMOTE_LINK_PARITY_EN and bad parity on 8'hA5 -> frame_err, only 8'h5A valid.

Source files
------------

// File: rtl/remote_link_rx_pkg.sv
// remote_link_pkg: definitions shared by the remote button link receiver and
// the matching transmitter.
//   - link_state_t : receiver FSM state encoding
//   - DEFAULT_*    : default clock and bit-rate figures
//   - SPACE_CODE / ENTER_CODE : command bytes carried on the link
//   - even_parity  : parity bit value that makes the frame's ones count even
// Optional feature macro: REMOTE_LINK_PARITY_EN (adds an even parity bit).
package remote_link_pkg;

    localparam int DEFAULT_CLK_HZ = 65_000_000;
    localparam int DEFAULT_BAUD   = 115_200;

    localparam logic [7:0] SPACE_CODE = 8'h20;
    localparam logic [7:0] ENTER_CODE = 8'h0D;

`ifdef REMOTE_LINK_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_RECOVER
    } link_state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/remote_link_rx_if.sv
// remote_link_rx_if: serial line plus the receiver's result strobes.
//   rx        : serial line from the peer (idle high)
//   rx_data   : last good byte
//   rx_valid  : good-frame strobe
//   btn_pulse : command-byte strobe
//   frame_err : bad stop / parity strobe
//   busy      : receiver not idle
// slave modport = receiver side, master modport = line driver / consumer.
interface remote_link_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       btn_pulse;
    logic       frame_err;
    logic       busy;

    modport master (output rx, input rx_data, rx_valid, btn_pulse, frame_err, busy);
    modport slave  (input rx, output rx_data, rx_valid, btn_pulse, frame_err, busy);
endinterface

// File: rtl/remote_link_sync.sv
// remote_link_sync: 2-FF synchronizer for an idle-high asynchronous line.
//   clk : destination clock
//   rst : synchronous active-high reset, forces both flops to 1 (idle level)
//   d   : asynchronous input
//   q   : synchronized output
module remote_link_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    (* ASYNC_REG = "TRUE" *) logic [1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= 2'b11;
        else     ff <= {ff[0], d};
    end

    assign q = ff[1];
endmodule

// File: rtl/remote_link_rx.sv
// remote_link_rx: UART-style receiver for the board-to-board button link.
// Recovers start/8 data (LSB first)/[parity]/stop frames and emits one-cycle
// strobes for good frames, command matches and framing errors.
//   clk65MHz : system clock
//   rst      : synchronous active-high reset
//   link     : remote_link_rx_if.slave (rx in; rx_data, rx_valid, btn_pulse,
//              frame_err, busy out)
// Optional feature macro: REMOTE_LINK_PARITY_EN (even parity bit after data).
module remote_link_rx
    import remote_link_pkg::*;
#(
    parameter int         CLK_HZ       = DEFAULT_CLK_HZ,
    parameter int         BAUD         = DEFAULT_BAUD,
    parameter int         CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter logic [7:0] CMD_CODE     = SPACE_CODE
) (
    input  logic            clk65MHz,
    input  logic            rst,
    remote_link_rx_if.slave link
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic          rx_s;
    link_state_t   state;
    logic [CW-1:0] cyc_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_err;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q, btn_pulse_q, frame_err_q;

    remote_link_sync u_sync (
        .clk (clk65MHz),
        .rst (rst),
        .d   (link.rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            state       <= ST_IDLE;
            cyc_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_err     <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            btn_pulse_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            btn_pulse_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state   <= ST_START;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                // Mid-start-bit check rejects short glitches silently.
                ST_START: begin
                    if (cyc_cnt == HALF) begin
                        cyc_cnt <= '0;
                        par_err <= 1'b0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cyc_cnt == FULL) begin
                        cyc_cnt <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
`ifdef REMOTE_LINK_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
`ifdef REMOTE_LINK_PARITY_EN
                ST_PARITY: begin
                    if (cyc_cnt == FULL) begin
                        cyc_cnt <= '0;
                        par_err <= (rx_s != even_parity(shreg));
                        state   <= ST_STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
`endif
                // Sampled mid-stop-bit, so the receiver is back in IDLE about
                // half a bit early and can take a back-to-back start edge.
                ST_STOP: begin
                    if (cyc_cnt == FULL) begin
                        cyc_cnt <= '0;
                        if (rx_s && !par_err) begin
                            rx_data_q   <= shreg;
                            rx_valid_q  <= 1'b1;
                            btn_pulse_q <= (shreg == CMD_CODE);
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state <= rx_s ? ST_IDLE : ST_RECOVER;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                // A held-low (break) line reports one error, then waits here.
                ST_RECOVER: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign link.rx_data   = rx_data_q;
    assign link.rx_valid  = rx_valid_q;
    assign link.btn_pulse = btn_pulse_q;
    assign link.frame_err = frame_err_q;
    assign link.busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_remote_link_rx.sv
// Self-checking bench for remote_link_rx (SPACE instance, CMD_CODE 8'h20).
// Expected bytes are queued when a frame is sent and popped by a monitor that
// watches rx_valid.
module tb_remote_link_rx;
    import remote_link_pkg::*;

    localparam int CPB  = 65_000_000 / 115_200;          // 564
    localparam int FAST = (CPB * 100 + 51) / 102;        // ~2% faster peer
`ifdef REMOTE_LINK_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // rx edge -> detect (3) -> start check (282) -> 8 data bits -> [parity] -> stop
    localparam int LAT = 3 + CPB / 2 + CPB * (NBITS - 1);

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_valid = 0, n_err = 0, n_btn = 0;
    int   t_start = 0, t_valid = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    remote_link_rx_if link();

    remote_link_rx #(
        .CLK_HZ(65_000_000), .BAUD(115_200), .CLKS_PER_BIT(CPB), .CMD_CODE(SPACE_CODE)
    ) dut (
        .clk65MHz (clk),
        .rst      (rst),
        .link     (link)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (link.rx_valid) begin
                n_valid++;
                t_valid = cyc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid got=%h want=none", link.rx_data);
                    exp_b = link.rx_data;
                end else begin
                    exp_b = exp_q.pop_front();
                    if (link.rx_data !== exp_b) begin
                        bad++;
                        $display("FAIL rx_data got=%h want=%h", link.rx_data, exp_b);
                    end
                end
                total++;
                if (link.btn_pulse !== (exp_b == SPACE_CODE)) begin
                    bad++;
                    $display("FAIL btn_pulse got=%b want=%b data=%h", link.btn_pulse,
                             (exp_b == SPACE_CODE), exp_b);
                end
                total++;
                if (link.frame_err !== 1'b0) begin
                    bad++;
                    $display("FAIL valid_err_excl got=%b want=0", link.frame_err);
                end
            end else if (link.btn_pulse) begin
                total++;
                bad++;
                $display("FAIL btn_without_valid got=1 want=0");
            end
            if (link.btn_pulse) n_btn++;
            if (link.frame_err) n_err++;
        end
    end

    // All stimulus timing is aligned to #1 after a rising edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input int bitc, input logic stop_v,
                             input logic par_flip);
        t_start = cyc;
        link.rx = 1'b0;
        wait_cyc(bitc);
        for (int i = 0; i < 8; i++) begin
            link.rx = d[i];
            wait_cyc(bitc);
        end
`ifdef REMOTE_LINK_PARITY_EN
        link.rx = even_parity(d) ^ par_flip;
        wait_cyc(bitc);
`else
        if (par_flip) begin end
`endif
        link.rx = stop_v;
        wait_cyc(bitc);
    endtask

    task automatic test_reset;
        int v, e;
        logic [7:0] d;
        rst = 1'b1;
        link.rx = 1'b1;
        wait_cyc(3);
        total++; if (link.rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx_data got=%h want=00", link.rx_data); end
        total++; if (link.rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b want=0", link.rx_valid); end
        total++; if (link.btn_pulse !== 1'b0) begin bad++; $display("FAIL rst_btn got=%b want=0", link.btn_pulse); end
        total++; if (link.frame_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", link.frame_err); end
        total++; if (link.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", link.busy); end
        rst = 1'b0;
        wait_cyc(2);
        // Start 8'h20 and abort in the middle of data bit 4.
        d = SPACE_CODE;
        v = n_valid;
        e = n_err;
        link.rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            link.rx = d[i];
            wait_cyc(CPB);
        end
        link.rx = d[4];
        wait_cyc(CPB / 2);
        total++; if (link.busy !== 1'b1) begin bad++; $display("FAIL midframe_busy got=%b want=1", link.busy); end
        rst = 1'b1;
        link.rx = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        total++; if (link.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", link.busy); end
        total++; if (link.rx_data !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h want=00", link.rx_data); end
        wait_cyc(CPB * 12);
        total++; if (n_valid !== v || n_err !== e) begin bad++; $display("FAIL midrst_silent valid=%0d err=%0d want=%0d,%0d", n_valid, n_err, v, e); end
        exp_q.push_back(SPACE_CODE);
        send_byte(SPACE_CODE, CPB, 1'b1, 1'b0);
        wait_cyc(4);
        total++; if (n_valid !== v + 1) begin bad++; $display("FAIL post_rst_frame valid=%0d want=%0d", n_valid, v + 1); end
    endtask

    task automatic test_cmd_match;
        int v, b;
        v = n_valid;
        b = n_btn;
        exp_q.push_back(SPACE_CODE);
        send_byte(SPACE_CODE, CPB, 1'b1, 1'b0);
        wait_cyc(2);
        total++; if (n_valid !== v + 1) begin bad++; $display("FAIL cmd_valid_cnt got=%0d want=%0d", n_valid, v + 1); end
        total++; if (n_btn !== b + 1) begin bad++; $display("FAIL cmd_btn_cnt got=%0d want=%0d", n_btn, b + 1); end
        total++; if (t_valid - t_start !== LAT) begin bad++; $display("FAIL cmd_latency got=%0d want=%0d", t_valid - t_start, LAT); end
        total++; if (link.busy !== 1'b0) begin bad++; $display("FAIL cmd_busy got=%b want=0", link.busy); end
    endtask

    task automatic test_non_cmd;
        int v, b;
        v = n_valid;
        b = n_btn;
        exp_q.push_back(ENTER_CODE);
        send_byte(ENTER_CODE, CPB, 1'b1, 1'b0);
        wait_cyc(2);
        total++; if (n_valid !== v + 1) begin bad++; $display("FAIL noncmd_valid_cnt got=%0d want=%0d", n_valid, v + 1); end
        total++; if (n_btn !== b) begin bad++; $display("FAIL noncmd_btn_cnt got=%0d want=%0d", n_btn, b); end
        total++; if (link.rx_data !== ENTER_CODE) begin bad++; $display("FAIL noncmd_hold got=%h want=%h", link.rx_data, ENTER_CODE); end
    endtask

    task automatic test_stop_err;
        int v, e;
        v = n_valid;
        e = n_err;
        send_byte(8'h33, CPB, 1'b0, 1'b0);   // line stays low afterwards
        wait_cyc(5000);
        total++; if (n_err !== e + 1) begin bad++; $display("FAIL stoperr_cnt got=%0d want=%0d", n_err, e + 1); end
        total++; if (n_valid !== v) begin bad++; $display("FAIL stoperr_valid got=%0d want=%0d", n_valid, v); end
        total++; if (link.rx_data !== ENTER_CODE) begin bad++; $display("FAIL stoperr_data got=%h want=%h", link.rx_data, ENTER_CODE); end
        total++; if (link.busy !== 1'b1) begin bad++; $display("FAIL stoperr_busy_low got=%b want=1", link.busy); end
        link.rx = 1'b1;
        wait_cyc(2);
        total++; if (link.busy !== 1'b1) begin bad++; $display("FAIL recover_busy_sync got=%b want=1", link.busy); end
        wait_cyc(2);
        total++; if (link.busy !== 1'b0) begin bad++; $display("FAIL recover_busy_idle got=%b want=0", link.busy); end
    endtask

    task automatic test_glitch;
        int v, e;
        v = n_valid;
        e = n_err;
        link.rx = 1'b0;
        wait_cyc(100);
        total++; if (link.busy !== 1'b1) begin bad++; $display("FAIL glitch_busy got=%b want=1", link.busy); end
        wait_cyc(100);
        link.rx = 1'b1;
        wait_cyc(300);
        total++; if (link.busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b want=0", link.busy); end
        total++; if (n_valid !== v || n_err !== e) begin bad++; $display("FAIL glitch_silent valid=%0d err=%0d want=%0d,%0d", n_valid, n_err, v, e); end
    endtask

    task automatic test_back_to_back;
        int v, e;
        v = n_valid;
        e = n_err;
`ifdef REMOTE_LINK_PARITY_EN
        send_byte(8'hA5, FAST, 1'b1, 1'b1);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, FAST, 1'b1, 1'b0);
        wait_cyc(CPB);
        total++; if (n_valid !== v + 1) begin bad++; $display("FAIL b2b_valid got=%0d want=%0d", n_valid, v + 1); end
        total++; if (n_err !== e + 1) begin bad++; $display("FAIL b2b_err got=%0d want=%0d", n_err, e + 1); end
`else
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        send_byte(8'hA5, FAST, 1'b1, 1'b0);
        send_byte(8'h5A, FAST, 1'b1, 1'b0);
        wait_cyc(CPB);
        total++; if (n_valid !== v + 2) begin bad++; $display("FAIL b2b_valid got=%0d want=%0d", n_valid, v + 2); end
        total++; if (n_err !== e) begin bad++; $display("FAIL b2b_err got=%0d want=%0d", n_err, e); end
`endif
        total++; if (link.rx_data !== 8'h5A) begin bad++; $display("FAIL b2b_last got=%h want=5A", link.rx_data); end
    endtask

    initial begin
        test_reset();
        test_cmd_match();
        test_non_cmd();
        test_stop_err();
        test_glitch();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_frames got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
